// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debouncer and its synchronizer:
//   - qualification state encodings (ST_IDLE / ST_CHECK)
//   - width of the optional rejected-glitch counter
//   - clog2 constant function used to size the stability counter
//   - saturating increment helper for the glitch counter
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_e;

   localparam int GLITCH_CNT_W = 8;

   // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(17) = 5
   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      while ((32'sd1 << r) < value) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
      logic [GLITCH_CNT_W-1:0] r;
      if (v == {GLITCH_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + GLITCH_CNT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/debouncer_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-stage single-bit synchronizer for asynchronous levels. Reusable for any
// asynchronous input entering the clk domain.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset; every stage loads RESET_LEVEL
//   d      in   asynchronous level
//   q      out  synchronized level (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int   N           = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   generate
      if (N < 2) begin : g_bad_stages
         $error("sync_ff: N must be at least 2");
      end
   endgenerate

   logic [N-1:0] chain_r;

   // Plain shift chain; nothing may sit between stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r <= {N{RESET_LEVEL}};
      end else begin
         chain_r <= {chain_r[N-2:0], d};
      end
   end

   assign q = chain_r[N-1];

endmodule

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Synchronizes a raw asynchronous level into clk and only lets a new level
// through once it has been seen for STABLE_CYCLES consecutive cycles. The
// clean registered level feeds the downstream edge detector.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-low reset
//   in          in   raw level, asynchronous to clk
//   out         out  debounced level (registered)
//   busy        out  high while a level change is being qualified
//   glitch_cnt  out  [7:0] saturating count of rejected glitches
//                    (only when DEBOUNCER_GLITCH_CNT_EN is defined)
//
// Build option: define DEBOUNCER_GLITCH_CNT_EN to add the glitch counter.
//
// Timing: out follows a change on in at edge SYNC_STAGES+STABLE_CYCLES after
// the change (first sampling edge = 1); busy rises at edge SYNC_STAGES+1 and
// drops on the edge where out updates.
// -----------------------------------------------------------------------------
module debouncer
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 16,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in,
   output logic                    out,
   output logic                    busy
`ifdef DEBOUNCER_GLITCH_CNT_EN
   ,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

   localparam int CNT_W = clog2(STABLE_CYCLES + 1);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("debouncer: SYNC_STAGES must be at least 2");
      end
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("debouncer: STABLE_CYCLES must be at least 1");
      end
   endgenerate

   logic             sync_q_s;
   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             out_r;
   logic             busy_r;
`ifdef DEBOUNCER_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_cnt_r;
`endif

   sync_ff #(
      .N           (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (in),
      .q     (sync_q_s)
   );

   // Qualification FSM: counts consecutive samples that disagree with out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         out_r        <= RESET_LEVEL;
         busy_r       <= 1'b0;
`ifdef DEBOUNCER_GLITCH_CNT_EN
         glitch_cnt_r <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (sync_q_s != out_r) begin
                  if (STABLE_CYCLES == 1) begin
                     // One differing sample is already enough
                     out_r   <= sync_q_s;
                     cnt_r   <= '0;
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     // This sample is the first of the run
                     cnt_r   <= CNT_W'(1);
                     state_r <= ST_CHECK;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  cnt_r   <= '0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (sync_q_s == out_r) begin
                  // Input went back: drop the run entirely, no partial credit
                  cnt_r   <= '0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
`ifdef DEBOUNCER_GLITCH_CNT_EN
                  glitch_cnt_r <= sat_inc(glitch_cnt_r);
`endif
               end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
                  // This is the STABLE_CYCLES-th consecutive differing sample
                  out_r   <= sync_q_s;
                  cnt_r   <= '0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  state_r <= ST_CHECK;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = out_r;
   assign busy = busy_r;
`ifdef DEBOUNCER_GLITCH_CNT_EN
   assign glitch_cnt = glitch_cnt_r;
`endif

endmodule
